// File: rtl/tt_sweep.sv
// tt_sweep: sweeps every minterm of an N-input reduction function chosen by
// mode, streaming (minterm, value) pairs and assembling the full truth table.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   start    in   sweep request, sampled only in IDLE
//   mode     in   [2:0] function select, latched when start is accepted
//   pause    in   freezes the sweep while high in SWEEP
//   minterm  out  [N-1:0] minterm currently presented
//   value    out  function result for minterm
//   valid    out  minterm/value pair valid this cycle
//   busy     out  sweep in progress (SWEEP state, including pauses)
//   done     out  one-cycle completion pulse
//   table_o  out  [2^N-1:0] truth table, bit m = f(m)
//   ones     out  [N:0] number of minterms with f = 1
module tt_sweep #(
  parameter int unsigned N = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic               pause,
  output logic [N-1:0]       minterm,
  output logic               value,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [(1<<N)-1:0]  table_o,
  output logic [N:0]         ones
);

  localparam int unsigned M  = 1 << N;
  localparam int unsigned CW = N + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      mode_q, mode_d;
  logic [N-1:0]    minterm_q, minterm_d;
  logic            value_q, value_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [M-1:0]    table_q, table_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic            f_c;

  // N-input reduction selected by the latched mode
  function automatic logic eval_f(input logic [2:0] md, input logic [N-1:0] m);
    logic r;
    r = 1'b0;
    case (md)
      3'b000:  r = &m;
      3'b001:  r = |m;
      3'b010:  r = ^m;
      3'b011:  r = ~(^m);
      3'b100:  r = ~(&m);
      3'b101:  r = ~(|m);
      3'b110:  r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Function value for the minterm the counter points at
  always_comb begin
    f_c = eval_f(mode_q, cnt_q[N-1:0]);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      minterm_q <= '0;
      value_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      table_q   <= '0;
      ones_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      minterm_q <= minterm_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      table_q   <= table_d;
      ones_q    <= ones_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    minterm_d = minterm_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    table_d   = table_q;
    ones_d    = ones_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          mode_d  = mode;
          cnt_d   = '0;
          table_d = '0;
          ones_d  = '0;
        end
      end
      S_SWEEP: begin
        if (!pause) begin
          // Counter runs one past the last minterm; that extra step is the
          // completion edge, so the wrap never starts a second pass.
          if (cnt_q == CW'(M)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            minterm_d = cnt_q[N-1:0];
            value_d   = f_c;
            valid_d   = 1'b1;
            table_d[cnt_q[N-1:0]] = f_c;
            ones_d    = ones_q + CW'(f_c);
            cnt_d     = cnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SWEEP);
  end

  assign minterm = minterm_q;
  assign value   = value_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign table_o = table_q;
  assign ones    = ones_q[N:0];

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 Parameter: N, default 2, number of logic inputs; legal range 1..6.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  sweep request; sampled only in IDLE.
REQ-005 Port: mode  input  3  function select; latched when start is accepted.
REQ-006 Port: pause  input  1  freezes the sweep while high in SWEEP.
REQ-007 Port: minterm  output  N  index of the minterm currently presented.
REQ-008 Port: value  output  1  function result for minterm.
REQ-009 Port: valid  output  1  minterm/value pair is valid this cycle.
REQ-010 Port: busy  output  1  sweep in progress.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: table  output  2^N  truth table; bit m = f(m).
REQ-013 Port: ones  output  N+1  count of minterms with f = 1.

Function
REQ-014 Inputs: minterm bit N-1 is the MSB input ("a"); bit 0 is the LSB input.
REQ-015 mode encodes an N-input reduction: 000 AND, 001 OR, 010 XOR, 011 XNOR (inverted XOR), 100 NAND, 101 NOR, 110 constant 0, 111 constant 1.
REQ-016 FSM states: IDLE, SWEEP, DONE.
REQ-017 IDLE -> SWEEP on a clock edge with start=1; at that edge the block latches mode and clears table and ones to 0, and loads the internal counter with 0.
REQ-018 In SWEEP with pause=0: outputs minterm=counter, value=f(counter), valid=1; writes table[counter]=value; increments ones if value=1; increments the counter.
REQ-019 In SWEEP with pause=1: counter, table and ones hold; valid=0; minterm holds its last value.
REQ-020 Valid minterms appear in order 0..2^N-1, once each, with no gaps other than pause cycles.
REQ-021 After minterm 2^N-1 is emitted, the FSM goes SWEEP -> DONE; the counter wrap is not allowed to start a second pass.
REQ-022 DONE lasts exactly one cycle: done=1, busy=0, valid=0, table and ones final; then DONE -> IDLE.
REQ-023 busy=1 exactly while in SWEEP, including pause cycles.
REQ-024 All outputs are registered.
REQ-025 Latency: the first valid occurs 1 cycle after start is accepted; done occurs 2^N+P+1 cycles after start is accepted, where P is the number of pause cycles.
REQ-026 start in SWEEP or DONE is ignored; it does not restart or queue.
REQ-027 A mode change after acceptance has no effect on the current sweep.
REQ-028 pause in IDLE or DONE is ignored.
REQ-029 table and ones hold their final values in IDLE until the next accepted start.
REQ-030 ones width N+1 holds the maximum 2^N (for example constant 1) without overflow.

Reset
REQ-031 While reset=1, asynchronously: state=IDLE, counter=0, minterm=0, value=0, valid=0, busy=0, done=0, table=0, ones=0.
REQ-032 Reset asserted mid-sweep aborts the sweep; no done pulse is produced, and table and ones read 0.
REQ-033 After reset is released, the first start is accepted on the first rising edge where reset=0.

Verification
REQ-034 N=2, mode=011 (XNOR), start pulse -> valid pairs (0,1),(1,0),(2,0),(3,1); done pulse; table=4'b1001; ones=2.
REQ-035 N=3, mode=010 (XOR), start pulse -> table=8'b10010110, ones=4, done 9 cycles after start.
REQ-036 N=2, mode=101 (NOR); pause=1 for 3 cycles after minterm 1 -> valid=0 during the pause, busy=1, sequence resumes at minterm 2; table=4'b0001, ones=1; done 8 cycles after start.
REQ-037 N=2, mode=111; start re-asserted during SWEEP and DONE -> ignored; single sweep; table=4'b1111, ones=4; one done pulse only.
REQ-038 N=3, mode=000; reset asserted after minterm 4 -> all outputs 0 immediately, no done; a new start then gives table=8'b10000000, ones=1.
